// File: rtl/apb_rmw_pkg.sv
// Shared types and constants for the APB read-modify-write master.
package apb_rmw_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_ACCESS = 3'd2,
    WR_SETUP  = 3'd3,
    WR_ACCESS = 3'd4,
    RESP      = 3'd5
  } apb_rmw_state_e;

  // Wide enough for any sane lane count; callers slice to STRB_WIDTH.
  localparam logic [127:0] FULL_STRB = '1;
  localparam logic [127:0] NO_STRB   = '0;

  function automatic bit data_width_ok(input int width);
    return (width > 0) && ((width % 8) == 0);
  endfunction

endpackage

// File: rtl/apb_master_byte_masking.sv
// Byte-lane merge: enabled lanes take the new write data, others keep the read word.
module apb_master_byte_masking #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic [STRB_WIDTH-1:0] pstrb_byte_mask,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic [DATA_WIDTH-1:0] PWDATA
);

  always_comb begin
    PWDATA = PRDATA;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (pstrb_byte_mask[i]) PWDATA[8*i +: 8] = apb_write_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/apb_master_rmw_ctrl.sv
// APB3 master: single-command sequencer, partial-strobe writes done as read-modify-write,
// with a PREADY watchdog.
//
//  state     | meaning
//  IDLE      | cmd_ready=1, waiting for a command
//  RD_SETUP  | read SETUP phase (PSEL=1, PENABLE=0)
//  RD_ACCESS | read ACCESS phase, waiting for PREADY
//  WR_SETUP  | write SETUP phase, PWDATA holds the merged word
//  WR_ACCESS | write ACCESS phase, waiting for PREADY
//  RESP      | one-cycle rsp_valid pulse
module apb_master_rmw_ctrl
  import apb_rmw_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [STRB_WIDTH-1:0] STRB_ALL  = FULL_STRB[STRB_WIDTH-1:0];
  localparam logic [STRB_WIDTH-1:0] STRB_NONE = NO_STRB[STRB_WIDTH-1:0];

  generate
    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
      $error("apb_master_rmw_ctrl: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  apb_rmw_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rd_q, rd_d, pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic                  write_q, write_d, pwrite_q, pwrite_d;
  logic                  psel_q, psel_d, penable_q, penable_d, cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]         wdog_q, wdog_d;

  logic [STRB_WIDTH-1:0] mask_strb;
  logic [DATA_WIDTH-1:0] mask_wdata, mask_rd, merged;
  logic                  wdog_hit;

  // Merge inputs are taken from whatever is about to be latched, so PWDATA is
  // already final on the first WR_SETUP cycle.
  always_comb begin
    mask_strb  = (state_q == IDLE) ? cmd_strb  : strb_q;
    mask_wdata = (state_q == IDLE) ? cmd_wdata : wdata_q;
    mask_rd    = (state_q == RD_ACCESS) ? PRDATA : rd_q;
  end

  apb_master_byte_masking #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_byte_mask (
    .pstrb_byte_mask (mask_strb),
    .apb_write_data  (mask_wdata),
    .PRDATA          (mask_rd),
    .PWDATA          (merged)
  );

  assign wdog_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    write_d       = write_q;
    rd_d          = rd_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    wdog_d        = wdog_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          strb_d  = cmd_strb;
          write_d = cmd_write;
          if (!cmd_write || (cmd_strb != STRB_ALL && cmd_strb != STRB_NONE)) begin
            state_d  = RD_SETUP;
            pwrite_d = 1'b0;
          end else if (cmd_strb == STRB_ALL) begin
            state_d  = WR_SETUP;
            pwrite_d = 1'b1;
            pwdata_d = merged;
          end else begin
            state_d       = RESP;
            rsp_rdata_d   = merged;
            rsp_err_d     = 1'b0;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      RD_SETUP: begin
        state_d = RD_ACCESS;
        wdog_d  = '0;
      end
      RD_ACCESS: begin
        if (PREADY) begin
          rd_d = PRDATA;
          if (PSLVERR || !write_q) begin
            state_d       = RESP;
            rsp_rdata_d   = PRDATA;
            rsp_err_d     = PSLVERR;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d  = WR_SETUP;
            pwrite_d = 1'b1;
            pwdata_d = merged;
          end
        end else if (wdog_hit) begin
          state_d       = RESP;
          rsp_rdata_d   = rd_q;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_ACCESS;
        wdog_d  = '0;
      end
      WR_ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          rsp_rdata_d   = pwdata_q;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (wdog_hit) begin
          state_d       = RESP;
          rsp_rdata_d   = pwdata_q;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == RD_SETUP) || (state_d == RD_ACCESS) ||
                  (state_d == WR_SETUP) || (state_d == WR_ACCESS);
    penable_d   = (state_d == RD_ACCESS) || (state_d == WR_ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      write_q       <= 1'b0;
      rd_q          <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      write_q       <= write_d;
      rd_q          <= rd_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wdog_q        <= wdog_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = addr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_rmw_ctrl.sv
// Bench for apb_master_rmw_ctrl: APB slave model, command driver and response scoreboard.
module tb_apb_master_rmw_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          PCLK, PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_master_rmw_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            chk_rdata;
    bit            err;
    bit            tmo;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0;

  always @(posedge PCLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            waits = 0, wcnt = 0;
  bit            hang = 0, err_rd = 0, err_wr = 0;
  int            n_setup, n_acc, n_rd, n_wr, n_unstable;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, last_pwdata;
  logic          s_write;

  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      n_setup++;
      s_addr  = PADDR;
      s_wdata = PWDATA;
      s_write = PWRITE;
    end
    if (PSEL && PENABLE) begin
      n_acc++;
      if (PADDR !== s_addr || PWRITE !== s_write || (PWRITE && PWDATA !== s_wdata))
        n_unstable++;
      if (!hang && wcnt == waits) begin
        PREADY  = 1'b1;
        PRDATA  = mem[PADDR];
        PSLVERR = PWRITE ? err_wr : err_rd;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        wcnt++;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      wcnt    = 0;
    end
  end

  always @(posedge PCLK) begin
    if (PRESETn && PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        if (!PSLVERR) mem[PADDR] = PWDATA;
        last_pwdata = PWDATA;
        n_wr++;
      end else begin
        n_rd++;
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge PCLK) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no command outstanding, expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        if (e.chk_rdata) chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic clr_counts();
    n_setup = 0; n_acc = 0; n_rd = 0; n_wr = 0; n_unstable = 0;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input bit push, input logic [DW-1:0] er,
                       input bit crd, input bit ee, input bit et, input int lat,
                       output int acc);
    int t;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge PCLK);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready=0 for 100 cycles, expected 1");
    end
    acc = cyc + 1;
    if (push) begin
      exp_t e;
      e.rdata = er; e.chk_rdata = crd; e.err = ee; e.tmo = et; e.lat = lat; e.acc = acc;
      sb_q.push_back(e);
    end
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge PCLK);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout_wait: %0d responses outstanding, expected 0", sb_q.size());
    end
    @(negedge PCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a1, a2, t;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    s_addr = '0; s_wdata = '0; s_write = 0; last_pwdata = '0;
    clr_counts();
    PRESETn = 0;
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", 64'({cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR}), 64'(0));
    PRESETn = 1;
    @(negedge PCLK);
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    // full write, zero wait
    clr_counts();
    issue(1, 12'h010, 32'hDEADBEEF, 4'hF, 1, 32'hDEADBEEF, 1, 0, 0, 3, a1);
    wait_done();
    chk("t1_setups", 64'(n_setup), 64'(1));
    chk("t1_reads", 64'(n_rd), 64'(0));
    chk("t1_writes", 64'(n_wr), 64'(1));
    chk("t1_pwdata", 64'(last_pwdata), 64'h0DEADBEEF);
    chk("t1_mem", 64'(mem[12'h010]), 64'h0DEADBEEF);

    // RMW, two wait states per phase
    mem[12'h020] = 32'h11223344; waits = 2;
    clr_counts();
    issue(1, 12'h020, 32'hAABBCCDD, 4'b0101, 1, 32'h11BB33DD, 1, 0, 0, 9, a1);
    wait_done();
    chk("t2_reads", 64'(n_rd), 64'(1));
    chk("t2_writes", 64'(n_wr), 64'(1));
    chk("t2_pwdata", 64'(last_pwdata), 64'h11BB33DD);
    chk("t2_mem", 64'(mem[12'h020]), 64'h11BB33DD);

    // RMW with read error
    mem[12'h030] = 32'h55667788; waits = 0; err_rd = 1;
    clr_counts();
    issue(1, 12'h030, 32'h00000000, 4'b0011, 1, '0, 0, 1, 0, 3, a1);
    wait_done();
    err_rd = 0;
    chk("t3_setups", 64'(n_setup), 64'(1));
    chk("t3_writes", 64'(n_wr), 64'(0));
    chk("t3_mem", 64'(mem[12'h030]), 64'h55667788);

    // plain read, one wait state
    mem[12'h050] = 32'hCAFEF00D; waits = 1;
    clr_counts();
    issue(0, 12'h050, '0, '0, 1, 32'hCAFEF00D, 1, 0, 0, 4, a1);
    wait_done();
    chk("rd_reads", 64'(n_rd), 64'(1));
    chk("rd_writes", 64'(n_wr), 64'(0));

    // watchdog: PREADY held low
    hang = 1; waits = 0;
    clr_counts();
    issue(0, 12'h040, '0, '0, 1, '0, 0, 1, 1, TO + 3, a1);
    wait_done();
    hang = 0;
    chk("t4_access_cycles", 64'(n_acc), 64'(TO + 1));
    chk("t4_psel_after", 64'(PSEL), 64'(0));
    chk("t4_cmd_ready", 64'(cmd_ready), 64'(1));

    // zero-strobe write: no bus activity
    clr_counts();
    issue(1, 12'h060, 32'h01234567, 4'b0000, 1, '0, 0, 0, 0, 1, a1);
    wait_done();
    chk("t5_setups", 64'(n_setup), 64'(0));
    chk("t5_access", 64'(n_acc), 64'(0));

    // back-to-back full writes
    clr_counts();
    issue(1, 12'h080, 32'h01020304, 4'hF, 1, 32'h01020304, 1, 0, 0, 3, a1);
    issue(1, 12'h084, 32'hA5A5A5A5, 4'hF, 1, 32'hA5A5A5A5, 1, 0, 0, 3, a2);
    wait_done();
    chk("b2b_accept_gap", 64'(a2 - a1), 64'(4));
    chk("b2b_mem0", 64'(mem[12'h080]), 64'h01020304);
    chk("b2b_mem1", 64'(mem[12'h084]), 64'hA5A5A5A5);

    // reset during WR_ACCESS
    waits = 5; mem[12'h070] = '0;
    clr_counts();
    issue(1, 12'h070, 32'h12345678, 4'hF, 0, '0, 0, 0, 0, 0, a1);
    t = 0;
    while (!(PSEL && PENABLE && PWRITE) && t < 20) begin
      @(negedge PCLK);
      t++;
    end
    chk("t6_reached_wr_access", 64'(PSEL && PENABLE && PWRITE), 64'(1));
    PRESETn = 0;
    @(negedge PCLK);
    chk("t6_outputs_zero", 64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE,
                               PWRITE, PADDR}), 64'(0));
    chk("t6_data_zero", {rsp_rdata, PWDATA}, 64'(0));
    @(negedge PCLK);
    PRESETn = 1;
    @(negedge PCLK);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("t6_no_write", 64'(n_wr), 64'(0));
    chk("t6_mem_untouched", 64'(mem[12'h070]), 64'(0));
    waits = 0;
    issue(1, 12'h070, 32'h12345678, 4'hF, 1, 32'h12345678, 1, 0, 0, 3, a1);
    wait_done();
    chk("t6_mem_after", 64'(mem[12'h070]), 64'h12345678);

    chk("apb_signals_stable", 64'(n_unstable), 64'(0));
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
